// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
//
// Data-memory access unit for the MEM pipeline stage. It decodes the
// access type from the opcode of the instruction in MEM, runs a single
// req/ack transaction on the data-memory bus, aligns and extends load data,
// and stalls the upstream pipeline until the access has completed.
//
// Sequence per access: IDLE (request latched) -> WAIT (req held until ack)
// -> DONE (one cycle, result valid, stall released) -> IDLE.
//
// Configuration macro:
//   MEM_TIMEOUT_EN  - when defined, WAIT is bounded by TIMEOUT_CYCLES. On
//                     expiry the access ends with load buffer 32'hDEADBEEF
//                     and mem_buserr high for the DONE cycle. When undefined,
//                     WAIT holds until ack and mem_buserr is tied low.
//
// Ports:
//   clk            clock, rising edge
//   rst            asynchronous, active-low reset
//   MEM_inst       instruction in MEM; [31:26] opcode selects access type
//   MEM_ALUout     effective byte address
//   MEM_storedata  store data (rt)
//   MEM_MemRead    load in MEM
//   MEM_MemWrite   store in MEM (wins over MemRead)
//   dmem_req       memory request, held for the whole WAIT state
//   dmem_we        1 = write
//   dmem_addr      word address
//   dmem_be        byte enables
//   dmem_wdata     lane-replicated store data
//   dmem_ack       single-cycle completion pulse, only honoured in WAIT
//   dmem_rdata     read word, valid with ack
//   MEM_dataout    aligned/extended load result, held between captures
//   mem_stall      freezes PC, IF/ID, ID/EX, EX/MEM
//   mem_misalign   misaligned access (combinational); no request issued
//   mem_buserr     timeout flag for one DONE cycle (MEM_TIMEOUT_EN only)
// ---------------------------------------------------------------------------
module mem_access_stage #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] MEM_inst,
   input  logic [31:0] MEM_ALUout,
   input  logic [31:0] MEM_storedata,
   input  logic        MEM_MemRead,
   input  logic        MEM_MemWrite,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic [31:0] MEM_dataout,
   output logic        mem_stall,
   output logic        mem_misalign,
   output logic        mem_buserr
);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;
   typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

   // Last WAIT-cycle count value before the timeout fires.
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

   // ------------------------------------------------------------------
   // Access decode
   // ------------------------------------------------------------------
   logic [5:0] opcode;
   logic [1:0] off;
   size_t      acc_size;
   logic       acc_signed;
   logic       access;
   logic [3:0] be_new;
   logic [31:0] wdata_new;

   assign opcode = MEM_inst[31:26];
   assign off    = MEM_ALUout[1:0];

   // NOTE: every variable written in an always_comb gets a default first, so
   // no path through the case leaves it unassigned and infers a latch.
   always_comb begin
      acc_size   = SZ_WORD;
      acc_signed = 1'b0;
      case (opcode)
         6'b100000:            begin acc_size = SZ_BYTE; acc_signed = 1'b1; end // lb
         6'b100100, 6'b101000:       acc_size = SZ_BYTE;                        // lbu, sb
         6'b100001:            begin acc_size = SZ_HALF; acc_signed = 1'b1; end // lh
         6'b100101, 6'b101001:       acc_size = SZ_HALF;                        // lhu, sh
         default:              ;                                                // lw, sw, others
      endcase
   end

   assign mem_misalign = (MEM_MemRead | MEM_MemWrite) &
                         (((acc_size == SZ_HALF) & off[0]) |
                          ((acc_size == SZ_WORD) & (off != 2'b00)));
   assign access = (MEM_MemRead | MEM_MemWrite) & ~mem_misalign;

   always_comb begin
      be_new    = 4'b1111;
      wdata_new = MEM_storedata;
      case (acc_size)
         SZ_BYTE: begin
            be_new    = 4'b0001 << off;
            wdata_new = {4{MEM_storedata[7:0]}};
         end
         SZ_HALF: begin
            be_new    = off[1] ? 4'b1100 : 4'b0011;
            wdata_new = {2{MEM_storedata[15:0]}};
         end
         default: ;
      endcase
   end

   // Lane select and sign/zero extension of a returned read word.
   function automatic logic [31:0] align_load(logic [31:0] word, logic [1:0] lane,
                                              size_t sz, logic sgn);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{lane, 3'b000} +: 8];
      h = lane[1] ? word[31:16] : word[15:0];
      case (sz)
         SZ_BYTE: align_load = {{24{sgn & b[7]}}, b};
         SZ_HALF: align_load = {{16{sgn & h[15]}}, h};
         default: align_load = word;
      endcase
   endfunction

   // ------------------------------------------------------------------
   // Transaction state
   // ------------------------------------------------------------------
   state_t      state_q, state_d;
   logic        req_q,   req_d;
   logic        we_q,    we_d;
   logic [31:0] addr_q,  addr_d;
   logic [3:0]  be_q,    be_d;
   logic [31:0] wdata_q, wdata_d;
   logic        load_q,  load_d;
   size_t       size_q,  size_d;
   logic        sign_q,  sign_d;
   logic [1:0]  off_q,   off_d;
   logic [31:0] buf_q,   buf_d;
`ifdef MEM_TIMEOUT_EN
   logic [7:0]  cnt_q,    cnt_d;
   logic        buserr_q, buserr_d;
`endif

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      load_d  = load_q;
      size_d  = size_q;
      sign_d  = sign_q;
      off_d   = off_q;
      buf_d   = buf_q;
`ifdef MEM_TIMEOUT_EN
      cnt_d    = cnt_q;
      buserr_d = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (access) begin
               state_d = ST_WAIT;
               req_d   = 1'b1;
               we_d    = MEM_MemWrite;
               addr_d  = {MEM_ALUout[31:2], 2'b00};
               be_d    = be_new;
               wdata_d = wdata_new;
               // Alignment info is kept with the request so the capture
               // does not depend on the stalled inputs staying put.
               load_d  = ~MEM_MemWrite;
               size_d  = acc_size;
               sign_d  = acc_signed;
               off_d   = off;
`ifdef MEM_TIMEOUT_EN
               cnt_d   = 8'd0;
`endif
            end
         end
         ST_WAIT: begin
            if (dmem_ack) begin
               state_d = ST_DONE;
               req_d   = 1'b0;
               if (load_q) buf_d = align_load(dmem_rdata, off_q, size_q, sign_q);
            end
`ifdef MEM_TIMEOUT_EN
            else if (cnt_q == TMO_LAST) begin
               state_d  = ST_DONE;
               req_d    = 1'b0;
               buf_d    = 32'hDEADBEEF;
               buserr_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
`endif
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= 32'd0;
         be_q    <= 4'd0;
         wdata_q <= 32'd0;
         load_q  <= 1'b0;
         size_q  <= SZ_WORD;
         sign_q  <= 1'b0;
         off_q   <= 2'd0;
         buf_q   <= 32'd0;
`ifdef MEM_TIMEOUT_EN
         cnt_q    <= 8'd0;
         buserr_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         load_q  <= load_d;
         size_q  <= size_d;
         sign_q  <= sign_d;
         off_q   <= off_d;
         buf_q   <= buf_d;
`ifdef MEM_TIMEOUT_EN
         cnt_q    <= cnt_d;
         buserr_q <= buserr_d;
`endif
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign dmem_req    = req_q;
   assign dmem_we     = we_q;
   assign dmem_addr   = addr_q;
   assign dmem_be     = be_q;
   assign dmem_wdata  = wdata_q;
   assign MEM_dataout = buf_q;
   assign mem_stall   = ((state_q == ST_IDLE) & access) | (state_q == ST_WAIT);

   logic unused_ok;
`ifdef MEM_TIMEOUT_EN
   assign mem_buserr = buserr_q;
   assign unused_ok  = ^MEM_inst[25:0];
`else
   assign mem_buserr = 1'b0;
   assign unused_ok  = ^{MEM_inst[25:0], TMO_LAST};
`endif

endmodule
